// File: rtl/nfifo_rd_sched.sv
// nfifo_rd_sched: round-robin read scheduler for the multi-flow NFIFO.
// Bounded bursts per flow, credit flow control, flow-tagged output stream.
module nfifo_rd_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 4,
  parameter int RD_LAT     = 1,
  parameter int BURST_LEN  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [FLOWS-1:0]         FLOW_EN,
  input  logic [FLOWS-1:0]         FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0]    FIFO_DATA_OUT,
  input  logic                     FIFO_DATA_VLD,
  output logic [$clog2(FLOWS)-1:0] FIFO_RD_BLK_ADDR,
  output logic                     FIFO_READ,
  output logic                     FIFO_PIPE_EN,
  output logic [DATA_WIDTH-1:0]    TX_DATA,
  output logic [$clog2(FLOWS)-1:0] TX_FLOW,
  output logic                     TX_SRC_RDY,
  input  logic                     TX_DST_RDY,
  output logic                     ERR_VLD
);

  localparam int FA = $clog2(FLOWS);
  localparam int D  = RD_LAT + 2;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(D);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(RD_LAT + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state, w_state_nx;
  logic [FA-1:0]   r_ptr, w_ptr_nx;
  logic [FA-1:0]   r_cur, w_cur_nx;
  logic [BW-1:0]   r_bcnt, w_bcnt_nx, w_bnext;
  logic            r_in_rst;
  logic [IW-1:0]   r_ign;
  logic [RD_LAT-1:0] r_tv;
  logic [FA-1:0]   r_tf [RD_LAT];
  logic [DATA_WIDTH-1:0] r_bd [D];
  logic [FA-1:0]   r_bf [D];
  logic [PW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic            w_found;
  logic [FA-1:0]   w_fidx, w_sidx;
  logic [CW-1:0]   w_infl;
  logic [CW:0]     w_used;
  logic            w_cred_ok;
  logic            w_rd;
  logic [FA-1:0]   w_addr;
  logic            w_ret_v;
  logic [FA-1:0]   w_ret_f;
  logic            w_chk;
  logic            w_push, w_pop;

  // Reads in flight: one per valid tag stage.
  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LAT; i++)
      w_infl = w_infl + CW'(r_tv[i]);
  end

  assign w_used    = {1'b0, r_cnt} + {1'b0, w_infl};
  assign w_cred_ok = w_used < D[CW:0];

  // First enabled non-empty flow at or after the RR pointer.
  always_comb begin
    w_found = 1'b0;
    w_fidx  = r_ptr;
    w_sidx  = r_ptr;
    for (int i = FLOWS - 1; i >= 0; i--) begin
      w_sidx = r_ptr + FA'(i);
      if (FLOW_EN[w_sidx] && !FIFO_EMPTY[w_sidx]) begin
        w_found = 1'b1;
        w_fidx  = w_sidx;
      end
    end
  end

  assign w_bnext = r_bcnt + BW'(1);

  // Scheduler next state and read strobe.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cur_nx   = r_cur;
    w_bcnt_nx  = r_bcnt;
    w_rd       = 1'b0;
    w_addr     = '0;
    if (!r_in_rst) begin
      unique case (r_state)
        S_IDLE: begin
          w_addr = w_fidx;
          if (w_found && w_cred_ok) begin
            w_rd      = 1'b1;
            w_cur_nx  = w_fidx;
            w_bcnt_nx = BW'(1);
            if (BURST_LEN == 1)
              w_ptr_nx = w_fidx + FA'(1);
            else
              w_state_nx = S_BURST;
          end
        end
        S_BURST: begin
          w_addr = r_cur;
          if (!FLOW_EN[r_cur] || FIFO_EMPTY[r_cur]) begin
            w_state_nx = S_IDLE;
            w_ptr_nx   = r_cur + FA'(1);
          end else if (w_cred_ok) begin
            w_rd      = 1'b1;
            w_bcnt_nx = w_bnext;
            if (w_bnext == BW'(BURST_LEN)) begin
              w_state_nx = S_IDLE;
              w_ptr_nx   = r_cur + FA'(1);
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Remembers that the previous edge saw reset; outputs stay quiet.
  always_ff @(posedge CLK) begin
    r_in_rst <= ~RESET;
  end

  // Scheduler state register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cur   <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_cur   <= w_cur_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  // Window after reset in which returns of discarded reads are ignored.
  always_ff @(posedge CLK) begin
    if (!RESET)
      r_ign <= IW'(RD_LAT);
    else if (r_ign != '0)
      r_ign <= r_ign - IW'(1);
  end

  // Flow tag travels alongside each read for RD_LAT cycles.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_tv <= '0;
      for (int i = 0; i < RD_LAT; i++)
        r_tf[i] <= '0;
    end else begin
      r_tv[0] <= w_rd;
      r_tf[0] <= w_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tf[i] <= r_tf[i-1];
      end
    end
  end

  assign w_ret_v = r_tv[RD_LAT-1];
  assign w_ret_f = r_tf[RD_LAT-1];
  assign w_chk   = (r_ign == '0);
  assign w_push  = w_chk && FIFO_DATA_VLD && w_ret_v;
  assign w_pop   = (r_cnt != '0) && TX_DST_RDY;

  // Sticky error on any return that disagrees with the tag pipe.
  always_ff @(posedge CLK) begin
    if (!RESET)
      r_err <= 1'b0;
    else if (w_chk && (FIFO_DATA_VLD != w_ret_v))
      r_err <= 1'b1;
  end

  // Output buffer pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= (r_wp == PW'(D - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop)
        r_rp <= (r_rp == PW'(D - 1)) ? '0 : r_rp + PW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  // Output buffer storage; contents are masked while empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_bd[r_wp] <= FIFO_DATA_OUT;
      r_bf[r_wp] <= w_ret_f;
    end
  end

  assign FIFO_READ        = w_rd;
  assign FIFO_RD_BLK_ADDR = w_addr;
  assign FIFO_PIPE_EN     = ~r_in_rst;
  assign TX_SRC_RDY       = (r_cnt != '0);
  assign TX_DATA          = TX_SRC_RDY ? r_bd[r_rp] : '0;
  assign TX_FLOW          = TX_SRC_RDY ? r_bf[r_rp] : '0;
  assign ERR_VLD          = r_err;

endmodule

// File: tb/tb_nfifo_rd_sched.sv
// tb_nfifo_rd_sched: directed bench for the NFIFO read scheduler.
// Behavioural NFIFO read side with RD_LAT=2 feeds the DUT.
module tb_nfifo_rd_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  FLOW_EN;
  logic [3:0]  FIFO_EMPTY;
  logic [63:0] FIFO_DATA_OUT;
  logic        FIFO_DATA_VLD;
  logic [1:0]  FIFO_RD_BLK_ADDR;
  logic        FIFO_READ;
  logic        FIFO_PIPE_EN;
  logic [63:0] TX_DATA;
  logic [1:0]  TX_FLOW;
  logic        TX_SRC_RDY;
  logic        TX_DST_RDY;
  logic        ERR_VLD;

  always #5 CLK = ~CLK;

  nfifo_rd_sched #(
    .DATA_WIDTH(64),
    .FLOWS(4),
    .RD_LAT(2),
    .BURST_LEN(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .FLOW_EN(FLOW_EN),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA_OUT(FIFO_DATA_OUT),
    .FIFO_DATA_VLD(FIFO_DATA_VLD),
    .FIFO_RD_BLK_ADDR(FIFO_RD_BLK_ADDR),
    .FIFO_READ(FIFO_READ),
    .FIFO_PIPE_EN(FIFO_PIPE_EN),
    .TX_DATA(TX_DATA),
    .TX_FLOW(TX_FLOW),
    .TX_SRC_RDY(TX_SRC_RDY),
    .TX_DST_RDY(TX_DST_RDY),
    .ERR_VLD(ERR_VLD)
  );

  int          q_cnt [4];
  int          seq [4];
  logic        dl_v [2];
  logic [63:0] dl_d [2];
  int          rd_f [$];
  int          tx_f [$];
  logic [63:0] tx_d [$];
  int          exp_f [$];
  int          exp_i [$];
  int          illegal;
  int          n_chk;
  int          n_pass;

  function automatic logic [63:0] word(int f, int i);
    return 64'hD000_0000_0000_0000 | (64'(f) << 32) | 64'(i);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    FIFO_DATA_VLD = dl_v[1];
    FIFO_DATA_OUT = dl_d[1];
    for (int f = 0; f < 4; f++)
      FIFO_EMPTY[f] = (q_cnt[f] == 0);
  endtask

  task automatic load(int f, int n);
    q_cnt[f] = n;
    seq[f] = 0;
    FIFO_EMPTY[f] = (n == 0);
  endtask

  task automatic clr();
    rd_f.delete();
    tx_f.delete();
    tx_d.delete();
    exp_f.delete();
    exp_i.delete();
  endtask

  task automatic add(int f, int i0, int n);
    for (int k = 0; k < n; k++) begin
      exp_f.push_back(f);
      exp_i.push_back(i0 + k);
    end
  endtask

  task automatic tick();
    logic        rd;
    logic [63:0] d;
    int          a;
    #1;
    rd = 1'b0;
    d = '0;
    if (FIFO_READ === 1'b1) begin
      rd = 1'b1;
      a = int'(FIFO_RD_BLK_ADDR);
      if (FIFO_EMPTY[a] || !FLOW_EN[a]) illegal++;
      rd_f.push_back(a);
      d = word(a, seq[a]);
      seq[a]++;
      if (q_cnt[a] > 0) q_cnt[a]--;
    end
    if (TX_SRC_RDY === 1'b1 && TX_DST_RDY) begin
      tx_f.push_back(int'(TX_FLOW));
      tx_d.push_back(TX_DATA);
    end
    dl_v[1] = dl_v[0];
    dl_d[1] = dl_d[0];
    dl_v[0] = rd;
    dl_d[0] = d;
    @(posedge CLK);
    #1;
    drive();
    #1;
  endtask

  task automatic check_logs(string p);
    chk({p, "_rd_n"}, 64'(rd_f.size()), 64'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && i < rd_f.size(); i++)
      chk({p, "_rd_flow"}, 64'(rd_f[i]), 64'(exp_f[i]));
    chk({p, "_tx_n"}, 64'(tx_f.size()), 64'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && i < tx_f.size(); i++) begin
      chk({p, "_tx_flow"}, 64'(tx_f[i]), 64'(exp_f[i]));
      chk({p, "_tx_data"}, tx_d[i], word(exp_f[i], exp_i[i]));
    end
  endtask

  task automatic chk_reset(string p);
    chk({p, "_read"}, 64'(FIFO_READ), 64'd0);
    chk({p, "_pipe_en"}, 64'(FIFO_PIPE_EN), 64'd0);
    chk({p, "_addr"}, 64'(FIFO_RD_BLK_ADDR), 64'd0);
    chk({p, "_src_rdy"}, 64'(TX_SRC_RDY), 64'd0);
    chk({p, "_tx_data"}, TX_DATA, 64'd0);
    chk({p, "_tx_flow"}, 64'(TX_FLOW), 64'd0);
    chk({p, "_err"}, 64'(ERR_VLD), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    illegal = 0;
    for (int f = 0; f < 4; f++) begin
      q_cnt[f] = 0;
      seq[f] = 0;
    end
    dl_v[0] = 1'b0;
    dl_v[1] = 1'b0;
    dl_d[0] = '0;
    dl_d[1] = '0;
    RESET = 1'b0;
    FLOW_EN = 4'b1111;
    TX_DST_RDY = 1'b1;
    drive();

    // reset state
    tick();
    tick();
    chk_reset("t0");

    // flows 0 and 2, ten words each
    clr();
    load(0, 10);
    load(2, 10);
    add(0, 0, 8);
    add(2, 0, 8);
    add(0, 8, 2);
    add(2, 8, 2);
    RESET = 1'b1;
    for (int k = 0; k < 300 && tx_f.size() < 20; k++) tick();
    repeat (5) tick();
    check_logs("t1");
    chk("t1_err", 64'(ERR_VLD), 64'd0);
    chk("t1_pipe_en", 64'(FIFO_PIPE_EN), 64'd1);

    // short flow 1 ends its burst on empty
    clr();
    load(1, 3);
    add(1, 0, 3);
    for (int k = 0; k < 50 && rd_f.size() < 3; k++) tick();
    repeat (10) tick();
    check_logs("t2");

    // pointer moved to 2: flow 2 wins over flow 1
    clr();
    load(1, 1);
    load(2, 1);
    add(2, 0, 1);
    add(1, 0, 1);
    repeat (20) tick();
    check_logs("t2b");

    // backpressure: credits cap reads at D=4
    clr();
    TX_DST_RDY = 1'b0;
    load(0, 6);
    add(0, 0, 6);
    repeat (20) tick();
    chk("t3_rd_held", 64'(rd_f.size()), 64'd4);
    chk("t3_src_rdy", 64'(TX_SRC_RDY), 64'd1);
    chk("t3_head_data", TX_DATA, word(0, 0));
    chk("t3_head_flow", 64'(TX_FLOW), 64'd0);
    TX_DST_RDY = 1'b1;
    for (int k = 0; k < 80 && tx_f.size() < 6; k++) tick();
    repeat (5) tick();
    check_logs("t3");

    // flow 3 disabled mid-burst
    clr();
    load(3, 8);
    add(3, 0, 3);
    for (int k = 0; k < 40 && rd_f.size() < 3; k++) tick();
    FLOW_EN = 4'b0111;
    repeat (15) tick();
    check_logs("t4");
    clr();
    add(3, 3, 5);
    FLOW_EN = 4'b1111;
    for (int k = 0; k < 80 && tx_f.size() < 5; k++) tick();
    repeat (5) tick();
    check_logs("t4b");

    // stray data valid sets sticky error
    chk("t5_err_pre", 64'(ERR_VLD), 64'd0);
    FIFO_DATA_VLD = 1'b1;
    FIFO_DATA_OUT = word(0, 99);
    tick();
    chk("t5_err_set", 64'(ERR_VLD), 64'd1);
    repeat (5) tick();
    chk("t5_err_hold", 64'(ERR_VLD), 64'd1);

    // reset with reads in flight and words buffered
    clr();
    TX_DST_RDY = 1'b0;
    load(1, 10);
    for (int k = 0; k < 40 && rd_f.size() < 4; k++) tick();
    chk("t6_rd_before", 64'(rd_f.size()), 64'd4);
    chk("t6_buf_before", 64'(TX_SRC_RDY), 64'd1);
    chk("t6_err_before", 64'(ERR_VLD), 64'd1);
    RESET = 1'b0;
    tick();
    chk_reset("t6r");
    RESET = 1'b1;
    TX_DST_RDY = 1'b1;
    load(0, 2);
    clr();
    add(0, 0, 2);
    add(1, 4, 6);
    for (int k = 0; k < 150 && tx_f.size() < 8; k++) tick();
    repeat (10) tick();
    check_logs("t6");
    chk("t6_err_late", 64'(ERR_VLD), 64'd0);
    chk("t6_pipe_en", 64'(FIFO_PIPE_EN), 64'd1);
    chk("illegal_reads", 64'(illegal), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
